bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT, default 1, meaning extra strobe cycles per access; legal range 0..7.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST  in  1  reset; synchronous, active-high.
REQ-004 ireq  in  1  fetch-port request.
REQ-005 iaddr  in  16  fetch byte address; fetch is always a word read.
REQ-006 idone  out  1  one-cycle pulse: fetch access complete.
REQ-007 dreq  in  1  data-port request.
REQ-008 dwe  in  1  data-port access type: 1 = write, 0 = read.
REQ-009 dbyte  in  1  data-port access size: 1 = byte, 0 = word.
REQ-010 daddr  in  16  data byte address.
REQ-011 dwdata  in  16  data write value; a byte write uses bits [7:0].
REQ-012 ddone  out  1  one-cycle pulse: data access complete.
REQ-013 rdata  out  16  read result shared by both ports; valid in the done cycle and held until the next done.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 ABUS  out  16  memory address.
REQ-016 DBUS  inout  16  memory data.
REQ-017 nMREQ, nRD, nWR, nBHE, nBLE  out  1 each  active-low memory strobes.

Function
REQ-018 FSM states: IDLE, ADDR, STRB, DONE; transitions as follows.
- IDLE -> ADDR when either request is high.
- ADDR -> STRB unconditionally.
- STRB -> DONE after WAIT+1 cycles in STRB.
- DONE -> IDLE unconditionally.
REQ-019 Arbitration occurs only in IDLE and uses requests sampled that cycle.
- Data port has priority over fetch.
- Exception: after two consecutive data grants, a pending ireq wins.
REQ-020 The consecutive-data-grant counter behaves as follows.
- Cleared on any fetch grant.
- Saturates at 2.
- Unchanged when no grant occurs.
REQ-021 On the IDLE->ADDR edge, latch into internal registers: winner identity, address, type, size and write data. Requesters may change inputs afterwards.
REQ-022 ABUS drives the latched address in ADDR, STRB and DONE; it holds its last value in IDLE.
REQ-023 nMREQ is low in ADDR and STRB; high in IDLE and DONE.
REQ-024 nRD (read) or nWR (write) is low only in STRB; both high otherwise.
REQ-025 Byte lanes are asserted in ADDR and STRB only, as follows.
- Word access: nBHE = nBLE = 0.
- Byte access with addr[0] = 0: nBLE = 0 only.
- Byte access with addr[0] = 1: nBHE = 0 only.
REQ-026 Word accesses ignore addr[0]; ABUS still carries the full address.
REQ-027 DBUS is driven only in ADDR and STRB of a write; high-impedance at all other times.
REQ-028 Write data on DBUS: word writes drive dwdata; byte writes drive {dwdata[7:0], dwdata[7:0]}.
REQ-029 Read data is captured from DBUS on the final STRB cycle and placed on rdata as follows.
- Word read: full 16 bits.
- Low-byte read: {8'h00, DBUS[7:0]}.
- High-byte read: {8'h00, DBUS[15:8]}.
REQ-030 rdata is updated only by reads; writes leave it unchanged.
REQ-031 idone or ddone pulses high for exactly the DONE cycle, for the granted port only.
REQ-032 Latency from the IDLE cycle with the winning request to the done pulse is 3+WAIT cycles; back-to-back accesses occupy 4+WAIT cycles each.
REQ-033 A requester holding req high after its done is treated as a new request in the following IDLE.
REQ-034 Requests arriving outside IDLE are not queued; they are seen only if still high in IDLE.
REQ-035 When ireq and dreq are high in the same IDLE cycle, REQ-019 resolves the winner; the loser is not acknowledged.

Reset
REQ-036 When RST is high at a clock edge, the block enters IDLE regardless of state, including mid-access.
REQ-037 On reset, outputs and internal state take these values.
- ABUS = 16'h0000, rdata = 16'h0000.
- nMREQ = nRD = nWR = nBHE = nBLE = 1.
- DBUS high-impedance.
- idone = ddone = busy = 0.
- Grant counter = 0.
REQ-038 A reset during ADDR or STRB produces no done pulse and leaves rdata at 16'h0000.

Verification
REQ-039 WAIT=1; ireq with iaddr=16'h0100; memory returns 16'hBEEF. Required response:
- nRD low exactly 2 cycles; nBHE = nBLE = 0.
- idone pulses 4 cycles after the request cycle.
- rdata = 16'hBEEF.
REQ-040 dreq, dwe=1, dbyte=1, daddr=16'h0203, dwdata=16'h12A5. Required response:
- nBHE = 0, nBLE = 1.
- DBUS = 16'hA5A5 during ADDR and STRB; nWR low in STRB only.
- ddone pulses; rdata unchanged.
REQ-041 Low-byte read: daddr=16'h0010, memory word 16'h7F3C -> rdata = 16'h003C, nBLE = 0, nBHE = 1.
REQ-042 Priority and anti-starvation: ireq and dreq held high continuously.
- Grant order is D, D, I, D, D, I.
- Each access is separated by one IDLE cycle.
REQ-043 Reset mid-access: RST asserted during the second STRB cycle of a read. At the next edge:
- All strobes high, DBUS high-impedance.
- No done pulse; rdata = 16'h0000; busy = 0.
REQ-044 WAIT=0 word write: STRB lasts 1 cycle; ddone 3 cycles after the request cycle; DBUS high-impedance in DONE.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Two-port arbiter in front of a single asynchronous 16-bit memory bus.
// A fetch port issues word reads. A data port issues word or byte reads
// and writes. Each access runs through the same four-state sequence:
// IDLE -> ADDR -> STRB (WAIT+1 cycles) -> DONE -> IDLE.
// The data port normally wins. After two data grants in a row, a waiting
// fetch request takes the next slot.
//
// Parameters
//   WAIT    extra strobe cycles per access (0..7)
//
// Ports
//   CLK     clock; all state changes on the rising edge
//   RST     synchronous active-high reset
//   ireq    fetch request           iaddr   fetch byte address
//   idone   fetch done pulse
//   dreq    data request            dwe     1 = write, 0 = read
//   dbyte   1 = byte, 0 = word      daddr   data byte address
//   dwdata  write data; a byte write uses [7:0]
//   ddone   data done pulse
//   rdata   read result for both ports; held until the next read completes
//   busy    high whenever the sequencer is not in IDLE
//   ABUS    memory address          DBUS    memory data (bidirectional)
//   nMREQ, nRD, nWR, nBHE, nBLE     active-low memory strobes
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int WAIT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ireq,
    input  logic [15:0] iaddr,
    output logic        idone,
    input  logic        dreq,
    input  logic        dwe,
    input  logic        dbyte,
    input  logic [15:0] daddr,
    input  logic [15:0] dwdata,
    output logic        ddone,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [15:0] ABUS,
    inout  wire  [15:0] DBUS,
    output logic        nMREQ,
    output logic        nRD,
    output logic        nWR,
    output logic        nBHE,
    output logic        nBLE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        STRB = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index of the last strobe cycle, as a counter value.
    localparam logic [2:0] LAST_STRB = 3'(WAIT);

    // ------------------------------------------------------------------
    // State and latched request
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;       // strobe cycles already spent
    logic [1:0]  dcount_q, dcount_d;   // consecutive data grants, saturating
    logic        gnt_data_q, gnt_data_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [15:0] wdata_q, wdata_d;     // already lane-replicated for bytes
    logic [15:0] rdata_d;
    logic        drive_q;              // write data is on DBUS

    // Arbitration result in IDLE.
    logic        data_win;
    logic        fetch_win;

    // Next values of the registered bus strobes.
    logic        active_d;
    logic        nmreq_d, nrd_d, nwr_d, nbhe_d, nble_d;
    logic        drive_d, idone_d, ddone_d, busy_d;

    // ------------------------------------------------------------------
    // Next-state, arbitration and request latch
    // ------------------------------------------------------------------
    // NOTE: every variable gets its hold/default value before the case
    // statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        dcount_d   = dcount_q;
        gnt_data_d = gnt_data_q;
        addr_d     = addr_q;
        we_d       = we_q;
        byte_d     = byte_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata;
        data_win   = 1'b0;
        fetch_win  = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless it has already taken two slots in a row
                // and fetch is waiting.
                data_win  = dreq && !(ireq && (dcount_q == 2'd2));
                fetch_win = ireq && !data_win;

                if (data_win) begin
                    state_d    = ADDR;
                    gnt_data_d = 1'b1;
                    addr_d     = daddr;
                    we_d       = dwe;
                    byte_d     = dbyte;
                    wdata_d    = dbyte ? {dwdata[7:0], dwdata[7:0]} : dwdata;
                    dcount_d   = (dcount_q == 2'd2) ? 2'd2 : dcount_q + 2'd1;
                end else if (fetch_win) begin
                    state_d    = ADDR;
                    gnt_data_d = 1'b0;
                    addr_d     = iaddr;
                    we_d       = 1'b0;
                    byte_d     = 1'b0;
                    dcount_d   = 2'd0;
                end
            end

            ADDR: begin
                state_d = STRB;
                wait_d  = 3'd0;
            end

            STRB: begin
                if (wait_q == LAST_STRB) begin
                    state_d = DONE;
                    // Sample the memory on the last strobe cycle. Byte reads
                    // return the selected lane zero-extended.
                    if (!we_q) begin
                        if (!byte_q) begin
                            rdata_d = DBUS;
                        end else if (addr_q[0]) begin
                            rdata_d = {8'h00, DBUS[15:8]};
                        end else begin
                            rdata_d = {8'h00, DBUS[7:0]};
                        end
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Strobe decode from the next state
    // ------------------------------------------------------------------
    // The strobes are registered so the memory sees glitch-free edges.
    // They are decoded from the next state and next latched request, which
    // gives them the same timing as a decode of the current state.
    always_comb begin
        active_d = (state_d == ADDR) || (state_d == STRB);
        nmreq_d  = !active_d;
        nrd_d    = !((state_d == STRB) && !we_d);
        nwr_d    = !((state_d == STRB) && we_d);
        // Word accesses enable both lanes whatever addr[0] holds.
        nble_d   = !(active_d && (!byte_d || !addr_d[0]));
        nbhe_d   = !(active_d && (!byte_d || addr_d[0]));
        drive_d  = active_d && we_d;
        idone_d  = (state_d == DONE) && !gnt_data_d;
        ddone_d  = (state_d == DONE) && gnt_data_d;
        busy_d   = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            wait_q     <= 3'd0;
            dcount_q   <= 2'd0;
            gnt_data_q <= 1'b0;
            addr_q     <= 16'h0000;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            wdata_q    <= 16'h0000;
            rdata      <= 16'h0000;
            drive_q    <= 1'b0;
            nMREQ      <= 1'b1;
            nRD        <= 1'b1;
            nWR        <= 1'b1;
            nBHE       <= 1'b1;
            nBLE       <= 1'b1;
            idone      <= 1'b0;
            ddone      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            dcount_q   <= dcount_d;
            gnt_data_q <= gnt_data_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            wdata_q    <= wdata_d;
            rdata      <= rdata_d;
            drive_q    <= drive_d;
            nMREQ      <= nmreq_d;
            nRD        <= nrd_d;
            nWR        <= nwr_d;
            nBHE       <= nbhe_d;
            nBLE       <= nble_d;
            idone      <= idone_d;
            ddone      <= ddone_d;
            busy       <= busy_d;
        end
    end

    // The latched address is only loaded on a grant, so ABUS keeps the last
    // access address while idle.
    assign ABUS = addr_q;
    assign DBUS = drive_q ? wdata_q : 16'hzzzz;

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
    a_rd_wr_exclusive : assert property (@(posedge CLK) disable iff (RST)
        !(!nRD && !nWR));
    a_done_exclusive : assert property (@(posedge CLK) disable iff (RST)
        !(idone && ddone));
    a_strobe_in_cycle : assert property (@(posedge CLK) disable iff (RST)
        (!nRD || !nWR) |-> !nMREQ);

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. Two instances share the request inputs:
// u_w1 (WAIT=1) carries most scenarios, and u_w0 (WAIT=0) covers the
// single-strobe write. Each instance has its own DBUS with pull-ups and a
// memory model that drives the read word while nRD is low. When nothing
// drives the bus it reads all ones.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq, dreq, dwe, dbyte;
    logic [15:0] iaddr, daddr, dwdata;
    logic [15:0] mem_word;
    logic        sel;        // 1 = observe u_w1, 0 = observe u_w0

    logic        idone_0, ddone_0, busy_0, nmreq_0, nrd_0, nwr_0, nbhe_0, nble_0;
    logic [15:0] rdata_0, abus_0;
    wire  [15:0] dbus_0;
    logic        idone_1, ddone_1, busy_1, nmreq_1, nrd_1, nwr_1, nbhe_1, nble_1;
    logic [15:0] rdata_1, abus_1;
    wire  [15:0] dbus_1;

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT(0)) u_w0 (
        .CLK(clk), .RST(rst),
        .ireq(ireq), .iaddr(iaddr), .idone(idone_0),
        .dreq(dreq), .dwe(dwe), .dbyte(dbyte), .daddr(daddr), .dwdata(dwdata),
        .ddone(ddone_0), .rdata(rdata_0), .busy(busy_0),
        .ABUS(abus_0), .DBUS(dbus_0),
        .nMREQ(nmreq_0), .nRD(nrd_0), .nWR(nwr_0), .nBHE(nbhe_0), .nBLE(nble_0)
    );

    bus_arbiter #(.WAIT(1)) u_w1 (
        .CLK(clk), .RST(rst),
        .ireq(ireq), .iaddr(iaddr), .idone(idone_1),
        .dreq(dreq), .dwe(dwe), .dbyte(dbyte), .daddr(daddr), .dwdata(dwdata),
        .ddone(ddone_1), .rdata(rdata_1), .busy(busy_1),
        .ABUS(abus_1), .DBUS(dbus_1),
        .nMREQ(nmreq_1), .nRD(nrd_1), .nWR(nwr_1), .nBHE(nbhe_1), .nBLE(nble_1)
    );

    // Memory model and bus keepers.
    assign dbus_0 = (!nrd_0) ? mem_word : 16'hzzzz;
    assign dbus_1 = (!nrd_1) ? mem_word : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (dbus_0[i]);
        pullup (dbus_1[i]);
    end

    // Selected instance.
    wire        s_idone = sel ? idone_1 : idone_0;
    wire        s_ddone = sel ? ddone_1 : ddone_0;
    wire        s_busy  = sel ? busy_1  : busy_0;
    wire        s_nmreq = sel ? nmreq_1 : nmreq_0;
    wire        s_nrd   = sel ? nrd_1   : nrd_0;
    wire        s_nwr   = sel ? nwr_1   : nwr_0;
    wire        s_nbhe  = sel ? nbhe_1  : nbhe_0;
    wire        s_nble  = sel ? nble_1  : nble_0;
    wire [15:0] s_rdata = sel ? rdata_1 : rdata_0;
    wire [15:0] s_abus  = sel ? abus_1  : abus_0;
    wire [15:0] s_dbus  = sel ? dbus_1  : dbus_0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-window statistics gathered by observe().
    int          rd_lo, wr_lo, mreq_lo, bhe_lo, ble_lo;
    int          dbus_bad, leak, n_done, first_done, prev_done, gap_bad, both;
    logic [15:0] abus_seen;
    logic [15:0] seq;

    // Run n cycles after a request cycle. Cycle k is sampled just after
    // the k-th edge, so a done seen at k is k cycles after the request.
    task automatic observe(input int n, input bit hold, input bit is_write,
                           input logic [15:0] wexp);
        int gap;
        gap = sel ? 5 : 4;
        rd_lo = 0; wr_lo = 0; mreq_lo = 0; bhe_lo = 0; ble_lo = 0;
        dbus_bad = 0; leak = 0; n_done = 0; first_done = -1; prev_done = -1;
        gap_bad = 0; both = 0; abus_seen = 16'h0000; seq = 16'h0000;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (!hold && k == 1) begin
                ireq = 1'b0;
                dreq = 1'b0;
            end
            if (!s_nrd) rd_lo++;
            if (!s_nwr) wr_lo++;
            if (!s_nmreq) begin
                mreq_lo++;
                abus_seen = s_abus;
                if (!s_nbhe) bhe_lo++;
                if (!s_nble) ble_lo++;
                if (is_write && s_dbus !== wexp) dbus_bad++;
            end else if (s_dbus !== 16'hFFFF) begin
                leak++;
            end
            if (s_idone || s_ddone) begin
                n_done++;
                if (s_idone && s_ddone) both++;
                if (first_done < 0) first_done = k;
                if (prev_done >= 0 && (k - prev_done) != gap) gap_bad++;
                prev_done = k;
                seq = {seq[14:0], s_ddone};
            end
        end
    endtask

    task automatic start_d(input logic we, input logic bsz,
                           input logic [15:0] a, input logic [15:0] wd);
        dreq = 1'b1; dwe = we; dbyte = bsz; daddr = a; dwdata = wd;
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; dbyte = 1'b0;
        iaddr = 16'h0000; daddr = 16'h0000; dwdata = 16'h0000;
        mem_word = 16'h0000; sel = 1'b1;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_abus",    s_abus, 16'h0000);
        check("rst_rdata",   s_rdata, 16'h0000);
        check("rst_strobes", {s_nmreq, s_nrd, s_nwr, s_nbhe, s_nble}, 5'b11111);
        check("rst_dbus",    s_dbus, 16'hFFFF);
        check("rst_flags",   {s_idone, s_ddone, s_busy}, 3'b000);

        // ---------------- fetch word read, WAIT=1 ----------------
        rst = 1'b0;
        mem_word = 16'hBEEF;
        ireq = 1'b1; iaddr = 16'h0100;
        observe(8, 1'b0, 1'b0, 16'h0000);
        check("fetch_nrd_cycles", rd_lo, 2);
        check("fetch_nwr_cycles", wr_lo, 0);
        check("fetch_mreq_cycles", mreq_lo, 3);
        check("fetch_lanes", {bhe_lo[7:0], ble_lo[7:0]}, {8'd3, 8'd3});
        check("fetch_abus", abus_seen, 16'h0100);
        check("fetch_done_at", first_done, 4);
        check("fetch_done_kind", seq[0], 1'b0);
        check("fetch_done_count", n_done, 1);
        check("fetch_rdata", s_rdata, 16'hBEEF);
        check("fetch_abus_idle", s_abus, 16'h0100);
        check("fetch_busy_idle", s_busy, 1'b0);
        check("fetch_dbus_leak", leak, 0);

        // ---------------- byte write, odd address ----------------
        start_d(1'b1, 1'b1, 16'h0203, 16'h12A5);
        observe(8, 1'b0, 1'b1, 16'hA5A5);
        check("bwr_nbhe_cycles", bhe_lo, 3);
        check("bwr_nble_cycles", ble_lo, 0);
        check("bwr_dbus_value", dbus_bad, 0);
        check("bwr_nwr_cycles", wr_lo, 2);
        check("bwr_nrd_cycles", rd_lo, 0);
        check("bwr_dbus_leak", leak, 0);
        check("bwr_done", {n_done[7:0], first_done[7:0], seq[0]}, {8'd1, 8'd4, 1'b1});
        check("bwr_rdata_kept", s_rdata, 16'hBEEF);

        // ---------------- low-byte and high-byte reads ----------------
        mem_word = 16'h7F3C;
        start_d(1'b0, 1'b1, 16'h0010, 16'h0000);
        observe(8, 1'b0, 1'b0, 16'h0000);
        check("lrd_rdata", s_rdata, 16'h003C);
        check("lrd_lanes", {bhe_lo[7:0], ble_lo[7:0]}, {8'd0, 8'd3});
        check("lrd_done_at", first_done, 4);

        start_d(1'b0, 1'b1, 16'h0011, 16'h0000);
        observe(8, 1'b0, 1'b0, 16'h0000);
        check("hrd_rdata", s_rdata, 16'h007F);
        check("hrd_lanes", {bhe_lo[7:0], ble_lo[7:0]}, {8'd3, 8'd0});

        // ---------------- WAIT=0 word write ----------------
        sel = 1'b0;
        start_d(1'b1, 1'b0, 16'h0400, 16'h5AC3);
        observe(8, 1'b0, 1'b1, 16'h5AC3);
        check("w0_nwr_cycles", wr_lo, 1);
        check("w0_mreq_cycles", mreq_lo, 2);
        check("w0_lanes", {bhe_lo[7:0], ble_lo[7:0]}, {8'd2, 8'd2});
        check("w0_dbus_value", dbus_bad, 0);
        check("w0_dbus_leak", leak, 0);
        check("w0_abus", abus_seen, 16'h0400);
        check("w0_done_at", first_done, 3);
        check("w0_done_kind", seq[0], 1'b1);

        // ---------------- priority and anti-starvation ----------------
        sel = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_word = 16'h1111;
        ireq = 1'b1; iaddr = 16'h0100;
        start_d(1'b0, 1'b0, 16'h0030, 16'h0000);
        observe(30, 1'b1, 1'b0, 16'h0000);
        ireq = 1'b0; dreq = 1'b0;
        check("prio_done_count", n_done, 6);
        check("prio_order", seq[5:0], 6'b110110);
        check("prio_spacing", gap_bad, 0);
        check("prio_first_at", first_done, 4);
        check("prio_one_hot", both, 0);

        // ---------------- reset in the second strobe cycle ----------------
        tick(); tick(); tick();
        mem_word = 16'h2222;
        start_d(1'b0, 1'b0, 16'h0040, 16'h0000);
        tick();
        dreq = 1'b0;
        tick();
        tick();
        check("mid_in_strb", {s_nmreq, s_nrd}, 2'b00);
        check("mid_rdata_before", s_rdata, 16'h1111);
        rst = 1'b1;
        tick();
        check("mid_strobes", {s_nmreq, s_nrd, s_nwr, s_nbhe, s_nble}, 5'b11111);
        check("mid_dbus", s_dbus, 16'hFFFF);
        check("mid_flags", {s_idone, s_ddone, s_busy}, 3'b000);
        check("mid_rdata", s_rdata, 16'h0000);
        rst = 1'b0;
        observe(4, 1'b0, 1'b0, 16'h0000);
        check("mid_no_done", n_done, 0);
        check("mid_rdata_after", s_rdata, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
